// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the hazard/forwarding controller: select encodings, the pipeline tag record,
// and the operand forwarding compare used once per source register.
package hazard_forward_unit_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic                      regwrite;
    logic                      memread;
  } tag_t;

  // A load still in EX has no ALU result to offer; that case is handled by the stall instead.
  function automatic logic [1:0] fwd_sel(input tag_t ex_tag, input tag_t mem_tag,
                                         input logic use_rs,
                                         input logic [REG_ADDR_W_DEF-1:0] rs);
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_rs) begin
      if (ex_tag.valid && ex_tag.regwrite && !ex_tag.memread &&
          (ex_tag.rd != '0) && (ex_tag.rd == rs)) begin
        sel = FWD_EXMEM;
      end else if (mem_tag.valid && mem_tag.regwrite &&
                   (mem_tag.rd != '0) && (mem_tag.rd == rs)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_tag_stage.sv
// One pipeline tag register {valid, rd, regwrite, memread}; loads every cycle,
// load_inv replaces the incoming tag with an invalid one.
module hazard_tag_stage
  import hazard_forward_unit_pkg::*;
(
  input  logic CLK,
  input  logic RESETn,
  input  logic load_inv,
  input  tag_t tag_in,
  output tag_t tag_q
);

  tag_t tag_d;

  always_comb begin
    tag_d = tag_in;
    if (load_inv) begin
      tag_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use stall / bubble control (combinational, same cycle) and EX operand forwarding selects
// (registered, valid while the instruction sits in EX); no backpressure other than the load-use stall.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  ID_VALID,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic                  ID_USE_RS1,
  input  logic                  ID_USE_RS2,
  input  logic [REG_ADDR_W-1:0] ID_RD,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  EX_FLUSH,
  output logic                  PC_WRITE,
  output logic                  IFID_WRITE,
  output logic                  IDEX_BUBBLE,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB,
  output logic [CNT_W-1:0]      STALL_COUNT
);

  tag_t             id_tag, ex_tag, mem_tag, wb_tag;
  logic             load_use, stall, bubble;
  logic [1:0]       fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    id_tag          = '0;
    id_tag.valid    = ID_VALID;
    id_tag.rd       = ID_RD;
    id_tag.regwrite = ID_RegWrite;
    id_tag.memread  = ID_MemRead;

    load_use = ID_VALID && ex_tag.valid && ex_tag.memread && (ex_tag.rd != '0) &&
               ((ID_USE_RS1 && (ex_tag.rd == ID_RS1)) ||
                (ID_USE_RS2 && (ex_tag.rd == ID_RS2)));
    // A taken branch squashes the dependent instruction anyway, so it wins over the stall.
    stall  = load_use && !EX_FLUSH;
    bubble = stall || EX_FLUSH;

    fwd_a_d = bubble ? FWD_RF : fwd_sel(ex_tag, mem_tag, ID_USE_RS1, ID_RS1);
    fwd_b_d = bubble ? FWD_RF : fwd_sel(ex_tag, mem_tag, ID_USE_RS2, ID_RS2);

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  hazard_tag_stage u_ex_tag (
    .CLK(CLK), .RESETn(RESETn), .load_inv(bubble), .tag_in(id_tag),  .tag_q(ex_tag)
  );
  hazard_tag_stage u_mem_tag (
    .CLK(CLK), .RESETn(RESETn), .load_inv(1'b0),   .tag_in(ex_tag),  .tag_q(mem_tag)
  );
  hazard_tag_stage u_wb_tag (
    .CLK(CLK), .RESETn(RESETn), .load_inv(1'b0),   .tag_in(mem_tag), .tag_q(wb_tag)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
    end else begin
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign PC_WRITE    = !stall;
  assign IFID_WRITE  = !stall;
  assign IDEX_BUBBLE = bubble;
  assign ForwardA    = fwd_a_q;
  assign ForwardB    = fwd_b_q;
  assign STALL_COUNT = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: instruction-stream vector table with a select scoreboard,
// plus hand-written reset-during-stall and counter saturation sequences.
module tb_hazard_forward_unit;

  localparam int CNT_W   = 6;
  localparam int SAT_MAX = (1 << CNT_W) - 1;

  logic             CLK, RESETn;
  logic             ID_VALID, ID_USE_RS1, ID_USE_RS2, ID_RegWrite, ID_MemRead, EX_FLUSH;
  logic [4:0]       ID_RS1, ID_RS2, ID_RD;
  logic             PC_WRITE, IFID_WRITE, IDEX_BUBBLE;
  logic [1:0]       ForwardA, ForwardB;
  logic [CNT_W-1:0] STALL_COUNT;

  hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESETn(RESETn), .ID_VALID(ID_VALID), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2), .ID_RD(ID_RD), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .EX_FLUSH(EX_FLUSH), .PC_WRITE(PC_WRITE), .IFID_WRITE(IFID_WRITE),
    .IDEX_BUBBLE(IDEX_BUBBLE), .ForwardA(ForwardA), .ForwardB(ForwardB), .STALL_COUNT(STALL_COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic       vld;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, mr, fl;
    logic       pcw, ifw, bub;
    logic [1:0] fa, fb;
    int         cnt;
  } vec_t;

  typedef struct {
    logic [1:0] fa, fb;
    int         row;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic vld, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic [4:0] rd, logic rw, logic mr, logic fl,
                              logic pcw, logic ifw, logic bub, logic [1:0] fa, logic [1:0] fb,
                              int cnt);
    vec_t v;
    v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.rw = rw; v.mr = mr; v.fl = fl; v.pcw = pcw; v.ifw = ifw; v.bub = bub;
    v.fa = fa; v.fb = fb; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ID_VALID = v.vld; ID_RS1 = v.rs1; ID_RS2 = v.rs2; ID_USE_RS1 = v.u1; ID_USE_RS2 = v.u2;
    ID_RD = v.rd; ID_RegWrite = v.rw; ID_MemRead = v.mr; EX_FLUSH = v.fl;
  endtask

  task automatic check_ctrl(input string nm, input logic pcw, input logic ifw, input logic bub);
    check({nm, "_pc_write"},    {31'd0, PC_WRITE},    {31'd0, pcw});
    check({nm, "_ifid_write"},  {31'd0, IFID_WRITE},  {31'd0, ifw});
    check({nm, "_idex_bubble"}, {31'd0, IDEX_BUBBLE}, {31'd0, bub});
  endtask

  vec_t idle;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0);
    //      vld rs1 rs2 u1 u2 rd rw mr fl | pcw ifw bub fa    fb    cnt
    vt.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0,  1, 1, 0, 2'b00, 2'b00, 0)); // add x5,x1,x2
    vt.push_back(mk(1, 5, 3, 1, 1, 6, 1, 0, 0,  1, 1, 0, 2'b10, 2'b00, 0)); // sub x6,x5,x3
    vt.push_back(mk(1, 4, 5, 1, 1, 7, 1, 0, 0,  1, 1, 0, 2'b00, 2'b01, 0)); // or  x7,x4,x5
    vt.push_back(mk(1, 7, 6, 1, 1, 9, 1, 0, 0,  1, 1, 0, 2'b10, 2'b01, 0)); // and x9,x7,x6
    vt.push_back(mk(1, 9, 9, 1, 0, 9, 1, 0, 0,  1, 1, 0, 2'b10, 2'b00, 0)); // addi x9,x9 (rs2 unused)
    vt.push_back(mk(1, 9, 0, 1, 1, 11, 1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 0)); // EX beats MEM on x9
    vt.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0,  1, 1, 0, 2'b00, 2'b00, 0)); // addi x0,x1,1
    vt.push_back(mk(1, 0, 0, 1, 1, 2, 1, 0, 0,  1, 1, 0, 2'b00, 2'b00, 0)); // add x2,x0,x0
    vt.push_back(mk(1, 0, 0, 1, 1, 3, 1, 0, 0,  1, 1, 0, 2'b00, 2'b00, 0)); // add x3,x0,x0
    vt.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0,  1, 1, 0, 2'b00, 2'b00, 0)); // lw x5
    vt.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0,  0, 0, 1, 2'b00, 2'b00, 0)); // add x6,x5,x5 stalls
    vt.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0,  1, 1, 0, 2'b01, 2'b01, 1)); // held, from MEM/WB
    vt.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 0,  1, 1, 0, 2'b00, 2'b00, 1)); // lw x0
    vt.push_back(mk(1, 0, 0, 1, 1, 7, 1, 0, 0,  1, 1, 0, 2'b00, 2'b00, 1)); // uses x0, no stall
    vt.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0,  1, 1, 0, 2'b00, 2'b00, 1)); // lw x5
    vt.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 1,  1, 1, 1, 2'b00, 2'b00, 1)); // dependent + flush
    vt.push_back(mk(1, 1, 5, 1, 1, 8, 1, 0, 0,  1, 1, 0, 2'b00, 2'b01, 1)); // x5 from MEM
    vt.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0,  1, 1, 0, 2'b00, 2'b00, 1)); // lw x5
    vt.push_back(mk(1, 5, 0, 1, 0, 6, 1, 1, 0,  0, 0, 1, 2'b00, 2'b00, 1)); // lw x6,0(x5) stalls
    vt.push_back(mk(1, 5, 0, 1, 0, 6, 1, 1, 0,  1, 1, 0, 2'b01, 2'b00, 2)); // held
    vt.push_back(mk(1, 6, 2, 1, 1, 7, 1, 0, 0,  0, 0, 1, 2'b00, 2'b00, 2)); // add x7,x6,x2 stalls
    vt.push_back(mk(1, 6, 2, 1, 1, 7, 1, 0, 0,  1, 1, 0, 2'b01, 2'b00, 3)); // held
    vt.push_back(mk(1, 7, 7, 1, 1, 1, 1, 0, 0,  1, 1, 0, 2'b10, 2'b10, 3)); // add x1,x7,x7

    drive(idle);
    RESETn = 1'b1;
    #1 RESETn = 1'b0;
    #1;
    check_ctrl("reset", 1'b1, 1'b1, 1'b0);
    check("reset_fwd_a", {30'd0, ForwardA}, 32'd0);
    check("reset_fwd_b", {30'd0, ForwardB}, 32'd0);
    check("reset_stall_count", {26'd0, STALL_COUNT}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RESETn = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      @(negedge CLK);
      check_ctrl($sformatf("row%0d", i), vt[i].pcw, vt[i].ifw, vt[i].bub);
      check($sformatf("row%0d_stall_count", i), {26'd0, STALL_COUNT}, vt[i].cnt);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("row%0d_fwd_a", e.row), {30'd0, ForwardA}, {30'd0, e.fa});
        check($sformatf("row%0d_fwd_b", e.row), {30'd0, ForwardB}, {30'd0, e.fb});
      end
      sb.push_back('{fa: vt[i].fa, fb: vt[i].fb, row: i});
      @(posedge CLK);
      #1;
    end
    drive(idle);
    @(negedge CLK);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check($sformatf("row%0d_fwd_a", e.row), {30'd0, ForwardA}, {30'd0, e.fa});
      check($sformatf("row%0d_fwd_b", e.row), {30'd0, ForwardB}, {30'd0, e.fb});
    end
    @(posedge CLK);
    #1;

    // Reset asserted in the middle of a stall cycle, with a live EX/MEM select and a non-zero count.
    drive(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0));
    @(posedge CLK); #1;
    drive(mk(1, 5, 0, 1, 0, 6, 1, 1, 0, 1, 1, 0, 2'b00, 2'b00, 0));
    @(posedge CLK); #1;
    drive(mk(1, 6, 6, 1, 1, 7, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0));
    @(negedge CLK);
    check_ctrl("pre_reset_stall", 1'b0, 1'b0, 1'b1);
    check("pre_reset_fwd_a", {30'd0, ForwardA}, 32'd2);
    check("pre_reset_stall_count", {26'd0, STALL_COUNT}, 32'd3);
    #2 RESETn = 1'b0;
    #1;
    check_ctrl("mid_reset", 1'b1, 1'b1, 1'b0);
    check("mid_reset_fwd_a", {30'd0, ForwardA}, 32'd0);
    check("mid_reset_fwd_b", {30'd0, ForwardB}, 32'd0);
    check("mid_reset_stall_count", {26'd0, STALL_COUNT}, 32'd0);
    @(posedge CLK);
    #1 RESETn = 1'b1;
    @(negedge CLK);
    check_ctrl("post_reset", 1'b1, 1'b1, 1'b0);

    // Saturation: lw x5,0(x5) repeated stalls every other cycle.
    drive(idle);
    RESETn = 1'b0;
    @(posedge CLK);
    #1 RESETn = 1'b1;
    drive(mk(1, 5, 0, 1, 0, 5, 1, 1, 0, 1, 1, 0, 2'b00, 2'b00, 0));
    begin
      int nst;
      int cyc;
      nst = 0;
      cyc = 0;
      while (nst < SAT_MAX + 4 && cyc < 400) begin
        @(negedge CLK);
        if (!PC_WRITE) nst++;
        if (nst == SAT_MAX && !PC_WRITE)
          check("count_before_last_unsat_stall", {26'd0, STALL_COUNT}, SAT_MAX - 1);
        cyc++;
      end
      check("sat_stalls_observed", nst, SAT_MAX + 4);
      @(posedge CLK);
      #1;
      check("sat_stall_count", {26'd0, STALL_COUNT}, SAT_MAX);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
